// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the transmit arbiter state encoding, the default byte width, and a
// width helper that never returns zero. The helper lets counters sized from
// a parameter that may be 0 or 1 still get a legal one-bit vector.
package uart_pkg;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        GAP  = 2'd3
    } arb_state_t;

    localparam int DEFAULT_DATA_BITS = 8;

    // Bits needed to index 'value' entries, never less than one.
    function automatic int safe_clog2(input int value);
        safe_clog2 = (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Round-robin winner selection (purely combinational).
// The search starts at ptr+1 and wraps modulo N_REQ. The first set request
// bit in that order wins.
// Ports:
//   req        request vector, one bit per requester
//   ptr        index of the previous winner
//   winner     index of the selected requester (only meaningful with any_valid)
//   any_valid  at least one request bit is set
module uart_rr_picker import uart_pkg::*; #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]             req,
    input  logic [safe_clog2(N_REQ)-1:0] ptr,
    output logic [safe_clog2(N_REQ)-1:0] winner,
    output logic                         any_valid
);

    localparam int IW = safe_clog2(N_REQ);

    // Walk candidates from farthest (ptr+N_REQ) to nearest (ptr+1).
    // The nearest set request is written last, so it wins.
    always_comb begin
        int              idx_v;
        logic [IW-1:0]   idx_s;
        winner = {IW{1'b0}};
        idx_v  = 0;
        idx_s  = {IW{1'b0}};
        for (int i = N_REQ; i >= 1; i--) begin
            idx_v  = (int'(ptr) + i) % N_REQ;
            idx_s  = idx_v[IW-1:0];
            winner = req[idx_s] ? idx_s : winner;
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte sources.
// One byte is accepted per frame over a valid/ready handshake. The arbiter
// then pulses tx_start, holds tx_din until the transmitter's tx_done, and
// optionally idles for GAP_CYCLES before arbitrating again.
//
// Optional feature macro: UART_TX_TIMEOUT_EN
//   When defined, a watchdog aborts a frame that sees no tx_done within
//   TIMEOUT_CYCLES and sets a sticky timeout flag. When undefined, timeout
//   is tied low and WAIT lasts until tx_done arrives.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   req_valid  per-requester byte available
//   req_data   packed bytes, requester i at [i*DATA_BITS +: DATA_BITS]
//   req_ready  one-hot, one-cycle accept pulse
//   tx_start   one-cycle start pulse to the transmitter
//   tx_din     byte being transmitted, stable for the whole frame
//   tx_done    end-of-frame pulse from the transmitter
//   grant_id   index of the current or last granted requester
//   busy       high whenever the arbiter is not in ARB
//   timeout    sticky watchdog flag
module uart_tx_arbiter import uart_pkg::*; #(
    parameter int N_REQ          = 4,
    parameter int DATA_BITS      = DEFAULT_DATA_BITS,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*DATA_BITS-1:0]   req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         tx_start,
    output logic [DATA_BITS-1:0]         tx_din,
    input  logic                         tx_done,
    output logic [$clog2(N_REQ)-1:0]     grant_id,
    output logic                         busy,
    output logic                         timeout
);

    localparam int IW = safe_clog2(N_REQ);
    localparam int GW = safe_clog2(GAP_CYCLES + 1);

    localparam int PTR_INIT_I = N_REQ - 1;
    localparam logic [IW-1:0] PTR_INIT = PTR_INIT_I[IW-1:0];
    localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [GW-1:0] GAP_LAST = GAP_LAST_I[GW-1:0];
    localparam logic [N_REQ-1:0] ONE_REQ = {{(N_REQ-1){1'b0}}, 1'b1};

    arb_state_t              state_r, state_nxt;
    logic [IW-1:0]           ptr_r, ptr_nxt;
    logic [N_REQ-1:0]        ready_r, ready_nxt;
    logic                    start_r, start_nxt;
    logic [DATA_BITS-1:0]    din_r, din_nxt;
    logic [IW-1:0]           gid_r, gid_nxt;
    logic                    busy_r, busy_nxt;
    logic [GW-1:0]           gap_r, gap_nxt;
    logic [IW-1:0]           winner_s;
    logic                    any_s;

`ifdef UART_TX_TIMEOUT_EN
    localparam int WW = safe_clog2(TIMEOUT_CYCLES + 1);
    localparam int WD_LAST_I = TIMEOUT_CYCLES - 1;
    localparam logic [WW-1:0] WD_LAST = WD_LAST_I[WW-1:0];

    logic [WW-1:0]           wd_r, wd_nxt;
    logic                    timeout_r, timeout_nxt;
`endif

    uart_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req       (req_valid),
        .ptr       (ptr_r),
        .winner    (winner_s),
        .any_valid (any_s)
    );

    // Next-state and next-output decode for the frame sequencer.
    always_comb begin
        state_nxt = state_r;
        ptr_nxt   = ptr_r;
        ready_nxt = {N_REQ{1'b0}};
        start_nxt = 1'b0;
        din_nxt   = din_r;
        gid_nxt   = gid_r;
        gap_nxt   = gap_r;
`ifdef UART_TX_TIMEOUT_EN
        wd_nxt      = wd_r;
        timeout_nxt = timeout_r;
`endif
        case (state_r)
            ARB: begin
                if (any_s) begin
                    state_nxt = LOAD;
                    ptr_nxt   = winner_s;
                    gid_nxt   = winner_s;
                    ready_nxt = ONE_REQ << winner_s;
                    din_nxt   = req_data[winner_s*DATA_BITS +: DATA_BITS];
                end else begin
                    state_nxt = ARB;
                end
            end
            // tx_start is raised one cycle after req_ready so the two never overlap.
            LOAD: begin
                start_nxt = 1'b1;
                state_nxt = WAIT;
`ifdef UART_TX_TIMEOUT_EN
                wd_nxt    = {WW{1'b0}};
`endif
            end
            WAIT: begin
                if (tx_done) begin
                    if (GAP_CYCLES > 0) begin
                        state_nxt = GAP;
                        gap_nxt   = {GW{1'b0}};
                    end else begin
                        state_nxt = ARB;
                    end
                end
`ifdef UART_TX_TIMEOUT_EN
                // The aborted requester already saw req_ready, so it is not retried.
                else if (wd_r == WD_LAST) begin
                    state_nxt   = ARB;
                    timeout_nxt = 1'b1;
                end else begin
                    wd_nxt = wd_r + WW'(1'b1);
                end
`else
                else begin
                    state_nxt = WAIT;
                end
`endif
            end
            GAP: begin
                if (gap_r == GAP_LAST) begin
                    state_nxt = ARB;
                end else begin
                    gap_nxt = gap_r + GW'(1'b1);
                end
            end
            default: begin
                state_nxt = ARB;
            end
        endcase
        busy_nxt = (state_nxt != ARB);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ARB;
            ptr_r   <= PTR_INIT;
            ready_r <= {N_REQ{1'b0}};
            start_r <= 1'b0;
            din_r   <= {DATA_BITS{1'b0}};
            gid_r   <= {IW{1'b0}};
            busy_r  <= 1'b0;
            gap_r   <= {GW{1'b0}};
        end else begin
            state_r <= state_nxt;
            ptr_r   <= ptr_nxt;
            ready_r <= ready_nxt;
            start_r <= start_nxt;
            din_r   <= din_nxt;
            gid_r   <= gid_nxt;
            busy_r  <= busy_nxt;
            gap_r   <= gap_nxt;
        end
    end

`ifdef UART_TX_TIMEOUT_EN
    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_r      <= {WW{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            wd_r      <= wd_nxt;
            timeout_r <= timeout_nxt;
        end
    end

    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

    assign req_ready = ready_r;
    assign tx_start  = start_r;
    assign tx_din    = din_r;
    assign grant_id  = gid_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter.
// Instance 0 uses GAP_CYCLES=0 and TIMEOUT_CYCLES=16. Instance 1 uses
// GAP_CYCLES=5. Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx_arbiter;

    localparam int GAP1 = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid [2];
    logic [31:0] req_data  [2];
    logic [3:0]  req_ready [2];
    logic        tx_start  [2];
    logic [7:0]  tx_din    [2];
    logic        tx_done   [2];
    logic [1:0]  grant_id  [2];
    logic        busy      [2];
    logic        timeout   [2];

    int total = 0;
    int bad   = 0;
    int n;

    logic [1:0] f_gid;
    logic [7:0] f_din;
    logic [3:0] f_rdy;

    logic [7:0] rr_din_exp [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    logic [1:0] rr_gid_exp [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] rr_rdy_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ(4), .DATA_BITS(8), .GAP_CYCLES(0), .TIMEOUT_CYCLES(16)
    ) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_data(req_data[0]),
        .req_ready(req_ready[0]), .tx_start(tx_start[0]), .tx_din(tx_din[0]),
        .tx_done(tx_done[0]), .grant_id(grant_id[0]), .busy(busy[0]), .timeout(timeout[0])
    );

    uart_tx_arbiter #(
        .N_REQ(4), .DATA_BITS(8), .GAP_CYCLES(GAP1), .TIMEOUT_CYCLES(4096)
    ) u_gap (
        .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_data(req_data[1]),
        .req_ready(req_ready[1]), .tx_start(tx_start[1]), .tx_din(tx_din[1]),
        .tx_done(tx_done[1]), .grant_id(grant_id[1]), .busy(busy[1]), .timeout(timeout[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Bounded wait for an accept pulse on instance d.
    task automatic wait_ready(input int d);
        int k;
        k = 0;
        while (req_ready[d] == 4'b0000 && k < 40) begin
            tick();
            k++;
        end
        check("ready_seen", 32'(req_ready[d] != 4'b0000), 32'd1);
    endtask

    // Complete one frame: accept, start, hold, then tx_done after dly cycles.
    task automatic frame(input int d, input int dly,
                         output logic [1:0] gid, output logic [7:0] din, output logic [3:0] rdy);
        wait_ready(d);
        check("ready_vs_start", 32'(tx_start[d]), 32'd0);
        rdy = req_ready[d];
        gid = grant_id[d];
        tick();
        check("ready_one_cycle", 32'(req_ready[d]), 32'd0);
        check("start_pulse", 32'(tx_start[d]), 32'd1);
        din = tx_din[d];
        repeat (dly - 1) tick();
        check("start_one_cycle", 32'(tx_start[d]), 32'd0);
        check("busy_in_wait", 32'(busy[d]), 32'd1);
        check("din_hold", 32'(tx_din[d]), 32'(din));
        tx_done[d] = 1'b1;
        tick();
        tx_done[d] = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 4'b0000;
            req_data[d]  = 32'h0000_0000;
            tx_done[d]   = 1'b0;
        end
        repeat (2) tick();
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", 32'(req_ready[d]), 32'd0);
            check("rst_start", 32'(tx_start[d]), 32'd0);
            check("rst_din", 32'(tx_din[d]), 32'd0);
            check("rst_gid", 32'(grant_id[d]), 32'd0);
            check("rst_busy", 32'(busy[d]), 32'd0);
            check("rst_timeout", 32'(timeout[d]), 32'd0);
        end
        reset = 1'b1;
        tick();

        // All four requesters continuously valid: grants rotate 0,1,2,3,0.
        req_data[0]  = 32'h1312_1110;
        req_valid[0] = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            frame(0, 10, f_gid, f_din, f_rdy);
            check("rr_din", 32'(f_din), 32'(rr_din_exp[k]));
            check("rr_gid", 32'(f_gid), 32'(rr_gid_exp[k]));
            check("rr_ready", 32'(f_rdy), 32'(rr_rdy_exp[k]));
        end
        req_valid[0] = 4'b0000;
        tick();

        // Pointer wrap: after requester 3, requester 0 beats requester 3.
        req_data[0]  = 32'h7700_003C;
        req_valid[0] = 4'b1000;
        frame(0, 4, f_gid, f_din, f_rdy);
        check("wrap_first_gid", 32'(f_gid), 32'd3);
        check("wrap_first_din", 32'(f_din), 32'h77);
        req_valid[0] = 4'b1001;
        frame(0, 4, f_gid, f_din, f_rdy);
        check("wrap_gid", 32'(f_gid), 32'd0);
        check("wrap_din", 32'(f_din), 32'h3C);
        req_valid[0] = 4'b0000;
        tick();

        // Single request: one-cycle accept latency, then start with the byte.
        req_data[0]  = 32'h00A5_0000;
        req_valid[0] = 4'b0100;
        tick();
        check("single_ready", 32'(req_ready[0]), 32'b0100);
        check("single_gid", 32'(grant_id[0]), 32'd2);
        check("single_busy", 32'(busy[0]), 32'd1);
        req_valid[0] = 4'b0000;
        frame(0, 4, f_gid, f_din, f_rdy);
        check("single_din", 32'(f_din), 32'hA5);
        check("idle_after_done", 32'(busy[0]), 32'd0);
        tx_done[0] = 1'b1;
        tick();
        tx_done[0] = 1'b0;
        tick();
        check("stray_done_busy", 32'(busy[0]), 32'd0);
        check("stray_done_start", 32'(tx_start[0]), 32'd0);

        // Frame spacing with a request pending: 1 cycle plus the gap.
        for (int d = 0; d < 2; d++) begin
            req_data[d]  = 32'h0000_00C0 + 32'(d);
            req_valid[d] = 4'b0001;
            frame(d, 3, f_gid, f_din, f_rdy);
            n = 0;
            while (req_ready[d] == 4'b0000 && n < 40) begin
                tick();
                n++;
            end
            check("spacing", 32'(n), (d == 0) ? 32'd1 : 32'(1 + GAP1));
            req_valid[d] = 4'b0000;
            frame(d, 3, f_gid, f_din, f_rdy);
            check("spacing_din", 32'(f_din), 32'h0000_00C0 + 32'(d));
        end
        repeat (8) tick();

        // Reset in WAIT clears outputs at once and restores the pointer.
        req_data[0]  = 32'h0000_665A;
        req_valid[0] = 4'b0001;
        wait_ready(0);
        req_valid[0] = 4'b0000;
        tick();
        tick();
        check("pre_reset_busy", 32'(busy[0]), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("midrst_ready", 32'(req_ready[0]), 32'd0);
        check("midrst_start", 32'(tx_start[0]), 32'd0);
        check("midrst_din", 32'(tx_din[0]), 32'd0);
        check("midrst_gid", 32'(grant_id[0]), 32'd0);
        check("midrst_busy", 32'(busy[0]), 32'd0);
        req_valid[0] = 4'b0011;
        tick();
        reset = 1'b1;
        tick();
        check("postrst_ready", 32'(req_ready[0]), 32'b0001);
        check("postrst_gid", 32'(grant_id[0]), 32'd0);
        check("postrst_din", 32'(tx_din[0]), 32'h5A);
        check("postrst_nostart", 32'(tx_start[0]), 32'd0);
        req_valid[0] = 4'b0000;
        frame(0, 3, f_gid, f_din, f_rdy);
        check("postrst_frame_din", 32'(f_din), 32'h5A);
        tick();

`ifdef UART_TX_TIMEOUT_EN
        // Watchdog: 16 cycles in WAIT without tx_done aborts the frame.
        req_data[0]  = 32'h00B2_B100;
        req_valid[0] = 4'b0010;
        wait_ready(0);
        req_valid[0] = 4'b0000;
        tick();
        n = 0;
        while (busy[0] && n < 40) begin
            tick();
            n++;
        end
        check("wd_cycles", 32'(n), 32'd16);
        check("wd_flag", 32'(timeout[0]), 32'd1);
        req_valid[0] = 4'b0100;
        frame(0, 3, f_gid, f_din, f_rdy);
        req_valid[0] = 4'b0000;
        check("wd_next_gid", 32'(f_gid), 32'd2);
        check("wd_next_din", 32'(f_din), 32'hB2);
        check("wd_sticky", 32'(timeout[0]), 32'd1);
`else
        // No watchdog: WAIT holds indefinitely and timeout stays low.
        req_data[0]  = 32'h0000_B100;
        req_valid[0] = 4'b0010;
        wait_ready(0);
        req_valid[0] = 4'b0000;
        repeat (31) tick();
        check("nowd_busy", 32'(busy[0]), 32'd1);
        check("nowd_timeout", 32'(timeout[0]), 32'd0);
        check("nowd_din", 32'(tx_din[0]), 32'hB1);
        tx_done[0] = 1'b1;
        tick();
        tx_done[0] = 1'b0;
        check("nowd_done_busy", 32'(busy[0]), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter between N_REQ independent byte sources.
- Accepts a byte from one requester per frame over a valid/ready handshake.
- Issues a one-cycle start pulse and byte to the transmitter, then waits for the transmitter's done pulse.
- Optionally inserts an inter-frame idle gap.
- Sits between client logic and the transmitter, mirroring the receive side's DATA_BITS framing.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_BITS, 8, byte width passed to transmitter
GAP_CYCLES, 0, idle clk cycles inserted after each frame (0 = no gap)
TIMEOUT_CYCLES, 4096, watchdog limit; used only with UART_TX_TIMEOUT_EN

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
req_valid  input  N_REQ  per-requester byte available
req_data  input  N_REQ*DATA_BITS  packed bytes; requester i at [i*DATA_BITS +: DATA_BITS]
req_ready  output  N_REQ  one-hot, one-cycle accept pulse
tx_start  output  1  one-cycle start pulse to transmitter
tx_din  output  DATA_BITS  byte to transmit, held stable until frame completes
tx_done  input  1  one-cycle pulse from transmitter at end of frame
grant_id  output  $clog2(N_REQ)  index of current or last granted requester
busy  output  1  high in any state except ARB
timeout  output  1  sticky watchdog flag (UART_TX_TIMEOUT_EN only; else tied 0)

Behaviour:
- Reset (reset low, async): state=ARB; req_ready=0, tx_start=0, tx_din=0, grant_id=0, busy=0, timeout=0.
  - RR pointer=N_REQ-1, so requester 0 wins first.
  - Reset mid-frame aborts immediately; no tx_start is re-issued after release.
- States (enum arb_state_t): ARB, LOAD, WAIT, GAP.
- ARB, no req_valid bits set: remain in ARB.
- ARB, any req_valid set:
  - Winner is the first set bit searching from pointer+1 upward, wrapping modulo N_REQ.
  - Same edge: capture req_data[winner] into tx_din, assert req_ready[winner] for exactly one cycle, set grant_id=winner, pointer=winner, go to LOAD.
  - Accept latency: 1 cycle from req_valid to req_ready.
- LOAD: assert tx_start for one cycle, go to WAIT.
- WAIT: tx_din held constant.
  - tx_done=1: go to GAP if GAP_CYCLES>0, else ARB.
  - tx_done=0: stay in WAIT.
  - tx_done asserted outside WAIT is ignored.
- GAP: counter counts from 0 to GAP_CYCLES-1, then go to ARB. Counter width $clog2(GAP_CYCLES+1).
- Minimum frame-to-frame spacing: tx_done to next req_ready is 1 cycle (ARB evaluation) plus GAP_CYCLES.
- A requester that drops req_valid before being granted is simply skipped; no state is kept per requester.
- Fairness: with all N_REQ continuously valid, grants cycle 0,1,..,N_REQ-1,0. No requester waits more than N_REQ-1 frames.
- tx_start and req_ready are never asserted in the same cycle.

Optional Feature:
Macro: UART_TX_TIMEOUT_EN
- Defined:
  - Watchdog counter runs in WAIT and clears on entry to WAIT.
  - On reaching TIMEOUT_CYCLES without tx_done: set timeout (sticky until reset) and go to ARB. The aborted requester is not retried.
- Undefined: no counter logic; timeout tied 0; WAIT waits indefinitely.

Decomposition:
- Shared package uart_pkg:
  - arb_state_t enum
  - DEFAULT_DATA_BITS constant
  - a clog2-safe width helper
- Sub-module uart_rr_picker (combinational): inputs req vector and pointer; outputs winner index and any_valid. Reusable by a future RX-side scheduler.

Test Plan:
- Single request, GAP_CYCLES=0:
  - Stimulus: req_valid=4'b0100, req_data[2]=8'hA5.
  - Response: req_ready=4'b0100 one cycle later; tx_start next cycle with tx_din=8'hA5; grant_id=2.
  - After tx_done, busy=0 the following cycle.
- All four requesters valid continuously, bytes 8'h10..8'h13, tx_done returned 10 cycles after each tx_start:
  - Response: tx_din sequence 10,11,12,13,10; exactly one req_ready bit per frame.
- Pointer wrap:
  - Stimulus: grant requester 3, then req_valid=4'b1001.
  - Response: next grant is requester 0, not 3.
- GAP_CYCLES=5:
  - Response: tx_done to next req_ready measures exactly 6 cycles with a request pending.
- Reset asserted during WAIT:
  - Response: outputs zero immediately; after release with req_valid=4'b0011, the first grant is requester 0.
- UART_TX_TIMEOUT_EN, TIMEOUT_CYCLES=16, tx_done never asserted:
  - Response: timeout=1 after 16 cycles in WAIT; state returns to ARB; the next request is still served.
